// File: rtl/hash_ctrl_pkg.sv
// Shared state encoding and width constants for the hash engine stream controller.
package hash_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, START, FEED, GAP, EOF} state_t;

  localparam int BYTE_W     = 8;
  localparam int DEF_HASH_W = 32;
  localparam int DEF_LEN_W  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W:0]        w_sum;
  logic                 w_found;

  // Rotating the request vector by the pointer turns the search into a plain priority encode.
  assign w_dbl   = {req, req} >> ptr;
  assign w_rot   = w_dbl[NUM_REQ-1:0];
  assign any_req = |req;

  always_comb begin
    grant   = '0;
    w_sum   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr} + (ID_W+1)'(k);
        if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
          w_sum = w_sum - (ID_W+1)'(NUM_REQ);
        end
        grant = w_sum[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hash_stream_arbiter.sv
// Shares one full_hash engine between byte-stream requesters, one whole message per grant,
// and returns hash, owner and length of each finished message.
module hash_stream_arbiter
  import hash_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int HASH_W  = DEF_HASH_W,
  parameter  int LEN_W   = DEF_LEN_W,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_byte,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      hs_start,
  output logic [BYTE_W-1:0]         hs_byte,
  output logic                      hs_dr,
  output logic                      hs_eof,
  input  logic                      hs_rtr,
  input  logic [HASH_W-1:0]         hs_rh,
  input  logic                      hs_ready,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [HASH_W-1:0]         res_hash,
  output logic [LEN_W-1:0]          res_len
);

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_grantId;
  logic [LEN_W-1:0]   r_count;
  logic               r_lastFlag;
  logic [ID_W-1:0]    w_arbGrant;
  logic               w_anyReq;
  logic [NUM_REQ-1:0] w_grantMask;
  logic [BYTE_W-1:0]  w_reqByte;
  logic               w_reqLast;
  logic               w_xfer;
  logic [ID_W-1:0]    w_nextPtr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .grant   (w_arbGrant),
    .any_req (w_anyReq)
  );

  assign w_grantMask = NUM_REQ'(1) << r_grantId;
  assign w_reqByte   = BYTE_W'(req_byte >> (BYTE_W * r_grantId));
  assign w_reqLast   = |(req_last & w_grantMask);
  assign req_ready   = (r_state == FEED && hs_rtr) ? w_grantMask : '0;
  assign w_xfer      = |(req_valid & req_ready);
  assign w_nextPtr   = (r_grantId == ID_W'(NUM_REQ-1)) ? '0 : r_grantId + 1'b1;
  assign busy        = (r_state != IDLE);
  assign grant_id    = r_grantId;

  // Pulse outputs default low each cycle; GAP exists so dr pulses can never be back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grantId  <= '0;
      r_count    <= '0;
      r_lastFlag <= 1'b0;
      hs_start   <= 1'b0;
      hs_byte    <= '0;
      hs_dr      <= 1'b0;
      hs_eof     <= 1'b0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      res_hash   <= '0;
      res_len    <= '0;
    end else begin
      hs_start  <= 1'b0;
      hs_dr     <= 1'b0;
      res_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grantId <= w_arbGrant;
            r_count   <= '0;
            hs_start  <= 1'b1;
            r_state   <= START;
          end
        end
        START: r_state <= FEED;
        FEED: begin
          if (w_xfer) begin
            hs_byte    <= w_reqByte;
            hs_dr      <= 1'b1;
            r_lastFlag <= w_reqLast;
            if (r_count != '1) begin
              r_count <= r_count + 1'b1;
            end
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_lastFlag) begin
            hs_eof  <= 1'b1;
            r_state <= EOF;
          end else begin
            r_state <= FEED;
          end
        end
        EOF: begin
          if (hs_ready) begin
            res_hash  <= hs_rh;
            res_len   <= r_count;
            res_id    <= r_grantId;
            res_valid <= 1'b1;
            hs_eof    <= 1'b0;
            r_ptr     <= w_nextPtr;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_stream_arbiter.sv
// Self-checking bench: byte sources, an FNV-1a engine model and a round-robin message-order model.
module tb_hash_stream_arbiter;

  localparam int NUM_REQ = 4;
  localparam int HASH_W  = 32;
  localparam int LEN_W   = 16;
  localparam int ID_W    = 2;
  localparam int QD      = 512;
  localparam int MD      = 32;
  localparam logic [31:0] FNV_OFF = 32'h811C9DC5;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*8-1:0]   req_byte;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   hs_start;
  logic [7:0]             hs_byte;
  logic                   hs_dr;
  logic                   hs_eof;
  logic                   hs_rtr;
  logic [HASH_W-1:0]      hs_rh;
  logic                   hs_ready;
  logic                   busy;
  logic [ID_W-1:0]        grant_id;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [HASH_W-1:0]      res_hash;
  logic [LEN_W-1:0]       res_len;

  hash_stream_arbiter #(
    .NUM_REQ (NUM_REQ),
    .HASH_W  (HASH_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_byte  (req_byte),
    .req_last  (req_last),
    .req_ready (req_ready),
    .hs_start  (hs_start),
    .hs_byte   (hs_byte),
    .hs_dr     (hs_dr),
    .hs_eof    (hs_eof),
    .hs_rtr    (hs_rtr),
    .hs_rh     (hs_rh),
    .hs_ready  (hs_ready),
    .busy      (busy),
    .grant_id  (grant_id),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_hash  (res_hash),
    .res_len   (res_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fnvStep(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'h0, b}) * 32'h01000193;
  endfunction

  int          checks;
  int          errors;
  int          stallMode;
  bit          bubbleEn;
  logic [9:0]  srcMem [NUM_REQ][QD];
  int          srcHead [NUM_REQ];
  int          srcTail [NUM_REQ];

  // Byte sources: {first, last, byte} entries, optional bubbles inside a message only.
  initial begin
    logic [NUM_REQ-1:0] acc;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) srcHead[i] = 0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) srcHead[i]++;
        if (srcHead[i] < srcTail[i] &&
            (srcMem[i][srcHead[i]][9] || !bubbleEn || $urandom_range(0, 3) != 0)) begin
          req_valid[i]       = 1'b1;
          req_byte[i*8 +: 8] = srcMem[i][srcHead[i]][7:0];
          req_last[i]        = srcMem[i][srcHead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Engine model: FNV-1a over the bytes it actually receives, rtr low after each dr.
  initial begin
    logic       sStart, sDr, sEof;
    logic [7:0] sByte;
    logic [31:0] accH;
    int         rtrWait, eofWait;
    bit         eofDone;
    hs_rtr = 1'b1; hs_ready = 1'b0; hs_rh = '0;
    accH = FNV_OFF; rtrWait = 0; eofWait = -1; eofDone = 0;
    forever begin
      @(negedge clk);
      sStart = hs_start; sDr = hs_dr; sEof = hs_eof; sByte = hs_byte;
      @(posedge clk);
      #1;
      hs_ready = 1'b0;
      hs_rh    = $urandom;
      if (!rst_n) begin
        hs_rtr = 1'b1; rtrWait = 0; eofWait = -1; eofDone = 0;
      end else begin
        if (sStart) accH = FNV_OFF;
        if (sDr) begin
          accH    = fnvStep(accH, sByte);
          rtrWait = (stallMode > 0) ? stallMode : 1 + $urandom_range(0, 2);
        end
        if (rtrWait > 0) begin
          hs_rtr = 1'b0;
          rtrWait--;
        end else begin
          hs_rtr = 1'b1;
        end
        if (!sEof) begin
          eofDone = 0;
          eofWait = -1;
        end else if (!eofDone) begin
          if (eofWait < 0) eofWait = $urandom_range(0, 3);
          if (eofWait == 0) begin
            hs_ready = 1'b1;
            hs_rh    = accH;
            eofDone  = 1;
          end else begin
            eofWait--;
          end
        end
      end
    end
  end

  logic [7:0]  drLog[$];
  int          drCyc[$];
  int          resIdQ[$];
  logic [31:0] resHashQ[$];
  int          resLenQ[$];
  int          startCnt, adjViol, foreignReady, readyNoRtr, eofViol;

  // Observer: logs engine traffic and results, counts protocol violations.
  initial begin
    bit prevDr, prevEof, prevReady;
    int cyc;
    startCnt = 0; adjViol = 0; foreignReady = 0; readyNoRtr = 0; eofViol = 0;
    prevDr = 0; prevEof = 0; prevReady = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prevDr = 0; prevEof = 0; prevReady = 0;
      end else begin
        if (hs_start) startCnt++;
        if (hs_dr) begin
          drLog.push_back(hs_byte);
          drCyc.push_back(cyc);
          if (prevDr) adjViol++;
        end
        if ((req_ready & ~(NUM_REQ'(1) << grant_id)) != '0) foreignReady++;
        if (req_ready != '0 && !hs_rtr) readyNoRtr++;
        if (prevEof && !prevReady && !hs_eof) eofViol++;
        if (res_valid) begin
          resIdQ.push_back(int'(res_id));
          resHashQ.push_back(res_hash);
          resLenQ.push_back(int'(res_len));
        end
        prevDr = hs_dr; prevEof = hs_eof; prevReady = hs_ready;
      end
    end
  end

  // Reference model: pending messages per requester and the resulting grant order.
  logic [31:0] mHash [NUM_REQ][MD];
  int          mLen  [NUM_REQ][MD];
  int          mHead [NUM_REQ];
  int          mTail [NUM_REQ];
  int          mPtr;
  int          expId[$];
  logic [31:0] expHash[$];
  int          expLen[$];
  int          expBase, resBase, startBase, drBase, expBytes, expMsgs;
  logic [7:0]  stim [64];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input int len);
    logic [31:0] h;
    h = FNV_OFF;
    for (int k = 0; k < len; k++) begin
      srcMem[id][srcTail[id] + k] = {k == 0, k == len - 1, stim[k]};
      h = fnvStep(h, stim[k]);
    end
    srcTail[id] += len;
    mHash[id][mTail[id]] = h;
    mLen[id][mTail[id]]  = len;
    mTail[id]++;
    expBytes += len;
    expMsgs++;
  endtask

  task automatic applyRandom(input int id, input int len);
    for (int k = 0; k < len; k++) stim[k] = 8'($urandom);
    applyStimulus(id, len);
  endtask

  task automatic predictOrder();
    bit more;
    more = 1;
    while (more) begin
      more = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int r;
        r = (mPtr + k) % NUM_REQ;
        if (!more && mHead[r] < mTail[r]) begin
          expId.push_back(r);
          expHash.push_back(mHash[r][mHead[r]]);
          expLen.push_back(mLen[r][mHead[r]]);
          mHead[r]++;
          mPtr = (r + 1) % NUM_REQ;
          more = 1;
        end
      end
    end
  endtask

  task automatic markBases();
    resBase = resIdQ.size(); expBase = expId.size();
    startBase = startCnt; drBase = drLog.size();
    expBytes = 0; expMsgs = 0;
  endtask

  task automatic waitAndCompare(input string tag, input int budget);
    int n, cyc;
    n = expId.size() - expBase;
    cyc = 0;
    while (resIdQ.size() - resBase < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #3;
    checkOutput({tag, "_results"}, resIdQ.size() - resBase, n);
    for (int k = 0; k < n; k++) begin
      if (resBase + k < resIdQ.size()) begin
        checkOutput($sformatf("%s_id%0d", tag, k), resIdQ[resBase + k], expId[expBase + k]);
        checkOutput($sformatf("%s_hash%0d", tag, k), resHashQ[resBase + k], expHash[expBase + k]);
        checkOutput($sformatf("%s_len%0d", tag, k), resLenQ[resBase + k], expLen[expBase + k]);
      end
    end
    checkOutput({tag, "_starts"}, startCnt - startBase, expMsgs);
    checkOutput({tag, "_drcount"}, drLog.size() - drBase, expBytes);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_adjdr"}, adjViol, 0);
    checkOutput({tag, "_foreign"}, foreignReady, 0);
    checkOutput({tag, "_rdynortr"}, readyNoRtr, 0);
    checkOutput({tag, "_eofhold"}, eofViol, 0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start"}, hs_start, 0);
    checkOutput({tag, "_byte"}, hs_byte, 0);
    checkOutput({tag, "_dr"}, hs_dr, 0);
    checkOutput({tag, "_eof"}, hs_eof, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_grant"}, grant_id, 0);
    checkOutput({tag, "_rvalid"}, res_valid, 0);
    checkOutput({tag, "_rid"}, res_id, 0);
    checkOutput({tag, "_rhash"}, res_hash, 0);
    checkOutput({tag, "_rlen"}, res_len, 0);
    checkOutput({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      srcTail[i] = srcHead[i];
      mHead[i]   = mTail[i];
    end
    mPtr = 0;
  endtask

  task automatic releaseReset();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    markBases();
  endtask

  initial begin
    string msg;
    int    cyc, id;
    checks = 0; errors = 0; stallMode = 0; bubbleEn = 0; mPtr = 0;
    expBytes = 0; expMsgs = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      srcTail[i] = 0; mHead[i] = 0; mTail[i] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    markBases();

    msg = "CiaoMondo";
    for (int k = 0; k < 9; k++) stim[k] = msg[k];
    applyStimulus(0, 9);
    predictOrder();
    waitAndCompare("ciao", 400);
    for (int k = 0; k < 9; k++) begin
      if (drBase + k < drLog.size()) checkOutput($sformatf("ciao_drbyte%0d", k), drLog[drBase + k], msg[k]);
    end

    doReset();
    releaseReset();
    applyRandom(1, $urandom_range(1, 6));
    applyRandom(3, $urandom_range(1, 6));
    predictOrder();
    waitAndCompare("contention", 400);
    checkOutput("contention_grant", grant_id, expId[expId.size() - 1]);

    doReset();
    releaseReset();
    applyRandom(0, 1); applyRandom(0, 1);
    applyRandom(1, 1); applyRandom(1, 1);
    applyRandom(2, 1); applyRandom(3, 1);
    predictOrder();
    waitAndCompare("fair", 600);

    stallMode = 5;
    markBases();
    applyRandom(2, 4);
    predictOrder();
    waitAndCompare("stall", 400);
    for (int k = 1; k < 4; k++) begin
      if (drBase + k < drCyc.size()) checkOutput($sformatf("stall_gap%0d", k), drCyc[drBase + k] - drCyc[drBase + k - 1], 7);
    end
    stallMode = 0;

    markBases();
    applyRandom(3, 1);
    predictOrder();
    waitAndCompare("single", 200);

    bubbleEn = 1;
    markBases();
    for (int m = 0; m < 8; m++) applyRandom($urandom_range(0, NUM_REQ - 1), $urandom_range(1, 8));
    predictOrder();
    waitAndCompare("random", 2000);
    bubbleEn = 0;

    doReset();
    releaseReset();
    applyRandom(0, 10);
    cyc = 0;
    while (drLog.size() - drBase < 3 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("midreset_progress", drLog.size() - drBase >= 3, 1'b1);
    doReset();
    #1;
    checkIdleOutputs("midreset");
    releaseReset();
    id = 2;
    applyRandom(id, 3);
    applyRandom(1, 2);
    predictOrder();
    waitAndCompare("afterreset", 400);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
